// File: rtl/wb_arbiter_3s2p_if.sv
// Bundle of the three result-source handshakes and the two register-file write ports
// shared between the writeback arbiter and its environment.
interface wb_arbiter_3s2p_if #(
  parameter int PREG_W = 6,
  parameter int DATA_W = 64
);
  logic              src0_valid;
  logic              src0_ready;
  logic [PREG_W-1:0] src0_preg;
  logic [DATA_W-1:0] src0_data;
  logic              src1_valid;
  logic              src1_ready;
  logic [PREG_W-1:0] src1_preg;
  logic [DATA_W-1:0] src1_data;
  logic              src2_valid;
  logic              src2_ready;
  logic [PREG_W-1:0] src2_preg;
  logic [DATA_W-1:0] src2_data;

  logic              wren0;
  logic [PREG_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              wren1;
  logic [PREG_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;

  modport slave (
    input  src0_valid, src0_preg, src0_data,
    input  src1_valid, src1_preg, src1_data,
    input  src2_valid, src2_preg, src2_data,
    output src0_ready, src1_ready, src2_ready,
    output wren0, waddr0, wdata0,
    output wren1, waddr1, wdata1
  );

  modport master (
    output src0_valid, src0_preg, src0_data,
    output src1_valid, src1_preg, src1_data,
    output src2_valid, src2_preg, src2_data,
    input  src0_ready, src1_ready, src2_ready,
    input  wren0, waddr0, wdata0,
    input  wren1, waddr1, wdata1
  );
endinterface

// File: rtl/wb_arbiter_3s2p.sv
// Writeback arbiter: three per-source result FIFOs, up to two round-robin grants per cycle
// onto the registered register-file write ports (which also serve as the wakeup broadcast).
module wb_arbiter_3s2p #(
  parameter int DEPTH  = 2,
  parameter int PREG_W = 6,
  parameter int DATA_W = 64
) (
  input logic             clock,
  input logic             reset_n,
  input logic             flush,
  wb_arbiter_3s2p_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2:0]        src_valid;
  logic [2:0]        src_ready;
  logic [PREG_W-1:0] src_preg [3];
  logic [DATA_W-1:0] src_data [3];

  logic [CNT_W-1:0]  count  [3];
  logic [PTR_W-1:0]  rd_ptr [3];
  logic [PTR_W-1:0]  wr_ptr [3];
  logic [PREG_W-1:0] preg_mem [3][DEPTH];
  logic [DATA_W-1:0] data_mem [3][DEPTH];
  logic [1:0]        rr;

  logic [2:0]        push;
  logic [2:0]        pop;
  logic [2:0]        nonempty;
  logic              g0_valid;
  logic              g1_valid;
  logic [1:0]        g0_src;
  logic [1:0]        g1_src;

  logic              wren0_q;
  logic              wren1_q;
  logic [PREG_W-1:0] waddr0_q;
  logic [PREG_W-1:0] waddr1_q;
  logic [DATA_W-1:0] wdata0_q;
  logic [DATA_W-1:0] wdata1_q;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  assign src_valid   = {bus.src2_valid, bus.src1_valid, bus.src0_valid};
  assign src_preg[0] = bus.src0_preg;
  assign src_preg[1] = bus.src1_preg;
  assign src_preg[2] = bus.src2_preg;
  assign src_data[0] = bus.src0_data;
  assign src_data[1] = bus.src1_data;
  assign src_data[2] = bus.src2_data;

  assign bus.src0_ready = src_ready[0];
  assign bus.src1_ready = src_ready[1];
  assign bus.src2_ready = src_ready[2];
  assign bus.wren0      = wren0_q;
  assign bus.waddr0     = waddr0_q;
  assign bus.wdata0     = wdata0_q;
  assign bus.wren1      = wren1_q;
  assign bus.waddr1     = waddr1_q;
  assign bus.wdata1     = wdata1_q;

  // Ready looks only at the registered count; a result for x0 is accepted but never queued.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      src_ready[n] = reset_n && !flush && (count[n] < CNT_W'(DEPTH));
      push[n]      = src_valid[n] && src_ready[n] && (src_preg[n] != '0);
      nonempty[n]  = (count[n] != '0);
    end
  end

  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    g0_valid = 1'b0;
    g1_valid = 1'b0;
    g0_src   = '0;
    g1_src   = '0;
    pop      = '0;
    if (!flush) begin
      for (int k = 0; k < 3; k++) begin
        idx = mod3_add(rr, 2'(k));
        if (nonempty[idx]) begin
          if (!g0_valid) begin
            g0_valid = 1'b1;
            g0_src   = idx;
            pop[idx] = 1'b1;
          end else if (!g1_valid) begin
            g1_valid = 1'b1;
            g1_src   = idx;
            pop[idx] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int n = 0; n < 3; n++) begin
      if (push[n]) begin
        preg_mem[n][wr_ptr[n]] <= src_preg[n];
        data_mem[n][wr_ptr[n]] <= src_data[n];
      end
    end
  end

  // Flush empties the queues and idles the ports but keeps the round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int n = 0; n < 3; n++) begin
        count[n]  <= '0;
        rd_ptr[n] <= '0;
        wr_ptr[n] <= '0;
      end
      rr       <= '0;
      wren0_q  <= 1'b0;
      wren1_q  <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else if (flush) begin
      for (int n = 0; n < 3; n++) begin
        count[n]  <= '0;
        rd_ptr[n] <= '0;
        wr_ptr[n] <= '0;
      end
      wren0_q <= 1'b0;
      wren1_q <= 1'b0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
        if (push[n] && !pop[n])      count[n] <= count[n] + CNT_W'(1);
        else if (!push[n] && pop[n]) count[n] <= count[n] - CNT_W'(1);
      end
      if (g1_valid)      rr <= mod3_add(g1_src, 2'd1);
      else if (g0_valid) rr <= mod3_add(g0_src, 2'd1);
      wren0_q <= g0_valid;
      wren1_q <= g1_valid;
      if (g0_valid) begin
        waddr0_q <= preg_mem[g0_src][rd_ptr[g0_src]];
        wdata0_q <= data_mem[g0_src][rd_ptr[g0_src]];
      end
      if (g1_valid) begin
        waddr1_q <= preg_mem[g1_src][rd_ptr[g1_src]];
        wdata1_q <= data_mem[g1_src][rd_ptr[g1_src]];
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter_3s2p.sv
// Directed self-checking bench for the 3-source / 2-port writeback arbiter.
module tb_wb_arbiter_3s2p;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bit       mon_on   = 0;
  bit       drive_on = 0;
  int       cyc      = 0;
  int       acc_cnt [3];
  int       wr_cnt  [3];
  int       win_cnt [3];
  logic [2:0] acc;

  wb_arbiter_3s2p_if #(.PREG_W(6), .DATA_W(64)) bus ();

  wb_arbiter_3s2p #(.DEPTH(2), .PREG_W(6), .DATA_W(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] satPreg(input int n, input int s);
    return 6'(((n * 21 + s) % 63) + 1);
  endfunction

  function automatic logic [63:0] satData(input int n, input int s);
    return {8'(n), 24'h0, 32'(s)};
  endfunction

  function automatic logic readyOf(input int n);
    case (n)
      0:       return bus.src0_ready;
      1:       return bus.src1_ready;
      default: return bus.src2_ready;
    endcase
  endfunction

  task automatic applyStimulus(input int n, input logic v, input logic [5:0] p, input logic [63:0] d);
    case (n)
      0: begin bus.src0_valid = v; bus.src0_preg = p; bus.src0_data = d; end
      1: begin bus.src1_valid = v; bus.src1_preg = p; bus.src1_data = d; end
      default: begin bus.src2_valid = v; bus.src2_preg = p; bus.src2_data = d; end
    endcase
  endtask

  task automatic clearAll();
    for (int n = 0; n < 3; n++) applyStimulus(n, 1'b0, 6'd0, 64'd0);
  endtask

  // Scoreboard for one write port in the saturation run: per-source order and address.
  task automatic portCheck(input logic [5:0] addr, input logic [63:0] data);
    int n;
    int s;
    n = int'(data[63:56]);
    s = int'(data[31:0]);
    if (n > 2) begin
      checkOutput("t4_src", 64'(n), 64'd0);
    end else begin
      checkOutput("t4_seq", 64'(s), 64'(wr_cnt[n]));
      checkOutput("t4_addr", 64'(addr), 64'(satPreg(n, wr_cnt[n])));
      wr_cnt[n]++;
      if (cyc >= 2 && cyc <= 31) win_cnt[n]++;
    end
  endtask

  task automatic monitor();
    cyc++;
    for (int n = 0; n < 3; n++) begin
      if (acc[n]) begin
        acc_cnt[n]++;
        if (drive_on) applyStimulus(n, 1'b1, satPreg(n, acc_cnt[n]), satData(n, acc_cnt[n]));
      end
    end
    if (bus.wren0) portCheck(bus.waddr0, bus.wdata0);
    if (bus.wren1) portCheck(bus.waddr1, bus.wdata1);
    checkOutput("t4_order", 64'(bus.wren1 && !bus.wren0), 64'd0);
    if (cyc >= 2 && cyc <= 31) checkOutput("t4_dual", 64'({bus.wren0, bus.wren1}), 64'd3);
    for (int n = 0; n < 3; n++)
      checkOutput("t4_ready", 64'(readyOf(n)), 64'((acc_cnt[n] - wr_cnt[n]) < 2));
  endtask

  task automatic tick();
    #1;
    acc = {bus.src2_valid && bus.src2_ready, bus.src1_valid && bus.src1_ready,
           bus.src0_valid && bus.src0_ready};
    @(posedge clock);
    #1;
    if (mon_on) monitor();
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clearAll();
    for (int n = 0; n < 3; n++) begin
      acc_cnt[n] = 0;
      wr_cnt[n]  = 0;
      win_cnt[n] = 0;
    end

    // Reset state
    idle(2);
    checkOutput("rst_wren0", 64'(bus.wren0), 64'd0);
    checkOutput("rst_wren1", 64'(bus.wren1), 64'd0);
    checkOutput("rst_waddr0", 64'(bus.waddr0), 64'd0);
    checkOutput("rst_wdata1", bus.wdata1, 64'd0);
    checkOutput("rst_ready0", 64'(bus.src0_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("rel_ready0", 64'(bus.src0_ready), 64'd1);

    // T1 single write, two-cycle latency
    applyStimulus(0, 1'b1, 6'd5, 64'hAA);
    tick();
    applyStimulus(0, 1'b0, 6'd0, 64'd0);
    checkOutput("t1_c1_wren0", 64'(bus.wren0), 64'd0);
    tick();
    checkOutput("t1_c2_wren0", 64'(bus.wren0), 64'd1);
    checkOutput("t1_c2_waddr0", 64'(bus.waddr0), 64'd5);
    checkOutput("t1_c2_wdata0", bus.wdata0, 64'hAA);
    checkOutput("t1_c2_wren1", 64'(bus.wren1), 64'd0);
    tick();
    checkOutput("t1_c3_wren0", 64'(bus.wren0), 64'd0);

    // Single grant on source 2 brings rr back to 0
    applyStimulus(2, 1'b1, 6'd9, 64'h99);
    tick();
    applyStimulus(2, 1'b0, 6'd0, 64'd0);
    tick();
    checkOutput("rr2_waddr0", 64'(bus.waddr0), 64'd9);
    checkOutput("rr2_wren1", 64'(bus.wren1), 64'd0);
    idle(2);

    // T2 contention from rr=0: (0,1) then 2
    applyStimulus(0, 1'b1, 6'd1, 64'h11);
    applyStimulus(1, 1'b1, 6'd2, 64'h22);
    applyStimulus(2, 1'b1, 6'd3, 64'h33);
    tick();
    clearAll();
    checkOutput("t2_c1_wren0", 64'(bus.wren0), 64'd0);
    tick();
    checkOutput("t2_c2_wren0", 64'(bus.wren0), 64'd1);
    checkOutput("t2_c2_waddr0", 64'(bus.waddr0), 64'd1);
    checkOutput("t2_c2_wdata0", bus.wdata0, 64'h11);
    checkOutput("t2_c2_wren1", 64'(bus.wren1), 64'd1);
    checkOutput("t2_c2_waddr1", 64'(bus.waddr1), 64'd2);
    checkOutput("t2_c2_wdata1", bus.wdata1, 64'h22);
    tick();
    checkOutput("t2_c3_wren0", 64'(bus.wren0), 64'd1);
    checkOutput("t2_c3_waddr0", 64'(bus.waddr0), 64'd3);
    checkOutput("t2_c3_wren1", 64'(bus.wren1), 64'd0);
    idle(2);

    // Single grant of source 2 left rr=0: sources 0 and 2 go out as port0=src0, port1=src2
    applyStimulus(0, 1'b1, 6'd4, 64'h44);
    applyStimulus(2, 1'b1, 6'd6, 64'h66);
    tick();
    clearAll();
    tick();
    checkOutput("t2b_waddr0", 64'(bus.waddr0), 64'd4);
    checkOutput("t2b_waddr1", 64'(bus.waddr1), 64'd6);
    checkOutput("t2b_wren1", 64'(bus.wren1), 64'd1);
    idle(2);

    // T3 result for x0 is accepted and dropped
    applyStimulus(1, 1'b1, 6'd0, 64'hFF);
    #1;
    checkOutput("t3_ready_c0", 64'(bus.src1_ready), 64'd1);
    tick();
    applyStimulus(1, 1'b0, 6'd0, 64'd0);
    checkOutput("t3_ready_c1", 64'(bus.src1_ready), 64'd1);
    checkOutput("t3_wren_c1", 64'({bus.wren0, bus.wren1}), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      checkOutput("t3_wren", 64'({bus.wren0, bus.wren1}), 64'd0);
    end

    // T4 saturation: all three sources valid every cycle
    cyc      = 0;
    mon_on   = 1;
    drive_on = 1;
    for (int n = 0; n < 3; n++) applyStimulus(n, 1'b1, satPreg(n, 0), satData(n, 0));
    idle(32);
    drive_on = 0;
    clearAll();
    idle(10);
    mon_on = 0;
    for (int n = 0; n < 3; n++) begin
      checkOutput("t4_drained", 64'(wr_cnt[n]), 64'(acc_cnt[n]));
      checkOutput("t4_fair", 64'(win_cnt[n] >= 19 && win_cnt[n] <= 21), 64'd1);
    end

    // T5 flush with three entries queued and a write in flight
    applyStimulus(0, 1'b1, 6'd10, 64'h10A);
    tick();
    applyStimulus(0, 1'b1, 6'd11, 64'h11);
    applyStimulus(1, 1'b1, 6'd12, 64'h12);
    applyStimulus(2, 1'b1, 6'd13, 64'h13);
    tick();
    clearAll();
    flush = 1'b1;
    #1;
    checkOutput("t5_k_ready", 64'({bus.src2_ready, bus.src1_ready, bus.src0_ready}), 64'd0);
    checkOutput("t5_k_wren0", 64'(bus.wren0), 64'd1);
    checkOutput("t5_k_waddr0", 64'(bus.waddr0), 64'd10);
    tick();
    flush = 1'b0;
    checkOutput("t5_k1_wren", 64'({bus.wren0, bus.wren1}), 64'd0);
    applyStimulus(1, 1'b1, 6'd7, 64'h77);
    #1;
    checkOutput("t5_k1_ready1", 64'(bus.src1_ready), 64'd1);
    tick();
    applyStimulus(1, 1'b0, 6'd0, 64'd0);
    checkOutput("t5_k2_wren", 64'({bus.wren0, bus.wren1}), 64'd0);
    tick();
    checkOutput("t5_k3_wren0", 64'(bus.wren0), 64'd1);
    checkOutput("t5_k3_waddr0", 64'(bus.waddr0), 64'd7);
    checkOutput("t5_k3_wdata0", bus.wdata0, 64'h77);
    checkOutput("t5_k3_wren1", 64'(bus.wren1), 64'd0);
    idle(2);

    // T6 reset with entries queued (rr is 2 beforehand)
    applyStimulus(0, 1'b1, 6'd21, 64'h21);
    applyStimulus(1, 1'b1, 6'd22, 64'h22);
    applyStimulus(2, 1'b1, 6'd23, 64'h23);
    tick();
    clearAll();
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_ready0", 64'(bus.src0_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    checkOutput("t6_wren", 64'({bus.wren0, bus.wren1}), 64'd0);
    checkOutput("t6_waddr0", 64'(bus.waddr0), 64'd0);
    checkOutput("t6_wdata0", bus.wdata0, 64'd0);
    checkOutput("t6_waddr1", 64'(bus.waddr1), 64'd0);
    checkOutput("t6_wdata1", bus.wdata1, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_no_stale", 64'({bus.wren0, bus.wren1}), 64'd0);
    end
    applyStimulus(1, 1'b1, 6'd30, 64'h30);
    applyStimulus(2, 1'b1, 6'd31, 64'h31);
    tick();
    clearAll();
    tick();
    checkOutput("t6_rr_waddr0", 64'(bus.waddr0), 64'd30);
    checkOutput("t6_rr_waddr1", 64'(bus.waddr1), 64'd31);
    checkOutput("t6_rr_wren", 64'({bus.wren0, bus.wren1}), 64'd3);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
